// File: rtl/hdmitx_pkg.sv
// Shared definitions for the HDMI TX link controller: FSM state encoding,
// TMDS control token and counter sizing helpers.
// Optional feature macro: HDMITX_LOCK_TIMEOUT_EN adds the MMCM_RST state.
package hdmitx_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_DEBOUNCE  = 3'd1,
        ST_SER_RST   = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_RUN       = 3'd4
`ifdef HDMITX_LOCK_TIMEOUT_EN
        ,
        ST_MMCM_RST  = 3'd5
`endif
    } state_e;

    // TMDS control token sent on every lane while video is blocked
    localparam logic [9:0]  CTRL_TOKEN = 10'b1101010100;
    localparam logic [29:0] CTRL_TOK3  = {3{CTRL_TOKEN}};

    function automatic int unsigned max4(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c,
        input int unsigned d
    );
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Bits needed to hold 0..max_val (counters saturate, never wrap)
    function automatic int cnt_width(input int unsigned max_val);
        if (max_val < 2) return 1;
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/hdmitx_link_ctrl_if.sv
// Link-side bundle of the HDMI TX link controller.
// Ports: tx_data_i (encoder words in), tx_data_o/tx_rst/mmcm_rst/link_up out.
interface hdmitx_link_ctrl_if;

    logic [29:0] tx_data_i;
    logic [29:0] tx_data_o;
    logic        tx_rst;
    logic        mmcm_rst;
    logic        link_up;

    // master: the link controller
    modport master (
        input  tx_data_i,
        output tx_data_o,
        output tx_rst,
        output mmcm_rst,
        output link_up
    );

    // slave: encoder / serializer side
    modport slave (
        output tx_data_i,
        input  tx_data_o,
        input  tx_rst,
        input  mmcm_rst,
        input  link_up
    );

endinterface

// File: rtl/hdmitx_sync2.sv
// Two-flop synchronizer with asynchronous active-low clear.
// Ports: clk_i, rst_ni (async clear), d_i (async in), q_o (synced out).
module hdmitx_sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ff_q <= 2'b00;
        end else begin
            ff_q <= {ff_q[0], d_i};
        end
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/hdmitx_link_ctrl.sv
// HDMI TX link bring-up: debounce MMCM lock, reset serializers, settle,
// then pass encoder words. Ports: pclk, rst_n, mmcm_locked, link (master).
// Optional: HDMITX_LOCK_TIMEOUT_EN enables MMCM reset on lock timeout.
module hdmitx_link_ctrl #(
    parameter int unsigned DEBOUNCE_CYC = 1024,
    parameter int unsigned RST_CYC      = 16,
    // must be at least 129
    parameter int unsigned SETTLE_CYC   = 256,
    parameter int unsigned LOCK_TIMEOUT = 1048576
) (
    input  logic               pclk,
    input  logic               rst_n,
    input  logic               mmcm_locked,
    hdmitx_link_ctrl_if.master link
);

    import hdmitx_pkg::*;

    localparam int unsigned CNT_MAX =
        max4(DEBOUNCE_CYC, RST_CYC, SETTLE_CYC, LOCK_TIMEOUT);
    localparam int CNT_W = cnt_width(CNT_MAX);

    localparam logic [CNT_W-1:0] DEB_LAST =
        CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] RST_LAST =
        CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] SET_LAST =
        CNT_W'(SETTLE_CYC - 1);
`ifdef HDMITX_LOCK_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST =
        CNT_W'(LOCK_TIMEOUT - 1);
`endif

    logic rst_sync_n;
    logic lock_s;

    // async assert, synchronous deassert of the internal reset
    hdmitx_sync2 u_rst_sync (
        .clk_i  (pclk),
        .rst_ni (rst_n),
        .d_i    (1'b1),
        .q_o    (rst_sync_n)
    );

    hdmitx_sync2 u_lock_sync (
        .clk_i  (pclk),
        .rst_ni (rst_sync_n),
        .d_i    (mmcm_locked),
        .q_o    (lock_s)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [29:0]      data_q, data_d;
    logic             tx_rst_q, tx_rst_d;
    logic             link_up_q, link_up_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_DEBOUNCE;
                end
`ifdef HDMITX_LOCK_TIMEOUT_EN
                else if (cnt_q == TMO_LAST) begin
                    state_d = ST_MMCM_RST;
                end
`endif
            end
            ST_DEBOUNCE: begin
                if (cnt_q == DEB_LAST) state_d = ST_SER_RST;
            end
            ST_SER_RST: begin
                if (cnt_q == RST_LAST) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == SET_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
`ifdef HDMITX_LOCK_TIMEOUT_EN
            ST_MMCM_RST: begin
                if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
            end
`endif
            default: begin
                state_d = ST_WAIT_LOCK;
            end
        endcase

        // Lock loss wins over any terminal count. MMCM_RST is
        // excluded: lock is expected low there and the pulse must finish.
        if (!lock_s &&
            (state_q == ST_DEBOUNCE || state_q == ST_SER_RST ||
             state_q == ST_SETTLE   || state_q == ST_RUN)) begin
            state_d = ST_WAIT_LOCK;
        end
    end

    // Shared counter: cleared on every state change, saturates otherwise
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Outputs are registered from next state so they change with it
    always_comb begin
        link_up_d = (state_d == ST_RUN);
        tx_rst_d  = !((state_d == ST_SETTLE) ||
                      (state_d == ST_RUN));
        data_d    = link_up_d ? link.tx_data_i : CTRL_TOK3;
    end

    always_ff @(posedge pclk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q   <= ST_WAIT_LOCK;
            cnt_q     <= '0;
            data_q    <= CTRL_TOK3;
            tx_rst_q  <= 1'b1;
            link_up_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            tx_rst_q  <= tx_rst_d;
            link_up_q <= link_up_d;
        end
    end

`ifdef HDMITX_LOCK_TIMEOUT_EN
    logic mmcm_rst_q, mmcm_rst_d;

    always_comb begin
        mmcm_rst_d = (state_d == ST_MMCM_RST);
    end

    always_ff @(posedge pclk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            mmcm_rst_q <= 1'b0;
        end else begin
            mmcm_rst_q <= mmcm_rst_d;
        end
    end

    assign link.mmcm_rst = mmcm_rst_q;
`else
    assign link.mmcm_rst = 1'b0;
`endif

    assign link.tx_data_o = data_q;
    assign link.tx_rst    = tx_rst_q;
    assign link.link_up   = link_up_q;

endmodule

// File: tb/tb_hdmitx_link_ctrl.sv
// Directed self-checking bench for hdmitx_link_ctrl.
// Covers bring-up timing, lock glitch/loss, mid-SETTLE reset, timeout.
module tb_hdmitx_link_ctrl;

    import hdmitx_pkg::*;

    localparam logic [29:0] TOK3 = 30'h354D5354;

    logic        pclk        = 1'b0;
    logic        rst_n       = 1'b0;
    logic        mmcm_locked = 1'b0;
    logic [29:0] prev_in     = '0;

    int n_checks = 0;
    int n_errors = 0;

    hdmitx_link_ctrl_if link ();

    hdmitx_link_ctrl #(
        .LOCK_TIMEOUT (100)
    ) dut (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .mmcm_locked (mmcm_locked),
        .link        (link)
    );

    always #5 pclk = ~pclk;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     tag, got, exp);
        end
    endtask

    // one pclk cycle; inputs change and outputs are sampled at negedge
    task automatic step();
        @(negedge pclk);
        prev_in        = link.tx_data_i;
        link.tx_data_i = 30'($urandom);
    endtask

    task automatic wait_tx_rst(
        input  logic val,
        input  int   budget,
        output int   n
    );
        n = 0;
        while (link.tx_rst !== val && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic wait_up(input int budget, output int n);
        n = 0;
        while (link.link_up !== 1'b1 && n < budget) begin
            step();
            n++;
        end
    endtask

    initial begin
        int  n;
        int  w;
        logic seen;

        link.tx_data_i = '0;

        // reset values
        step();
        step();
        check("rst_tx_rst", 32'(link.tx_rst), 1);
        check("rst_link_up", 32'(link.link_up), 0);
        check("rst_mmcm_rst", 32'(link.mmcm_rst), 0);
        check("rst_data", 32'(link.tx_data_o), 32'(TOK3));

        rst_n = 1'b1;
        repeat (8) step();
        check("pre_lock_tx_rst", 32'(link.tx_rst), 1);

        // bring-up: lock at cycle 10
        mmcm_locked = 1'b1;
        wait_tx_rst(1'b0, 3000, n);
        check("bringup_tx_rst_lat", n, 1043);
        check("settle_link_up", 32'(link.link_up), 0);
        check("settle_data", 32'(link.tx_data_o), 32'(TOK3));
        wait_up(400, n);
        check("bringup_up_lat", n, 256);
        check("run_first_word", 32'(link.tx_data_o), 32'(prev_in));
        for (int i = 0; i < 5; i++) begin
            step();
            check("run_pass", 32'(link.tx_data_o), 32'(prev_in));
        end

        // lock loss in RUN
        mmcm_locked = 1'b0;
        step();
        step();
        check("loss_up_hold", 32'(link.link_up), 1);
        step();
        check("loss_link_up", 32'(link.link_up), 0);
        check("loss_tx_rst", 32'(link.tx_rst), 1);
        check("loss_data", 32'(link.tx_data_o), 32'(TOK3));

        // 1-cycle lock glitch at debounce count ~500
        mmcm_locked = 1'b1;
        repeat (503) step();
        check("glitch_in_deb", 32'(link.tx_rst), 1);
        mmcm_locked = 1'b0;
        step();
        mmcm_locked = 1'b1;
        wait_tx_rst(1'b0, 3000, n);
        check("glitch_restart_lat", n, 1043);
        wait_up(400, n);
        check("glitch_up_lat", n, 256);

        // async reset pulse in SETTLE
        mmcm_locked = 1'b0;
        repeat (4) step();
        mmcm_locked = 1'b1;
        wait_tx_rst(1'b0, 3000, n);
        repeat (10) step();
        check("settle_before_rst", 32'(link.tx_rst), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_tx_rst", 32'(link.tx_rst), 1);
        check("arst_link_up", 32'(link.link_up), 0);
        check("arst_data", 32'(link.tx_data_o), 32'(TOK3));
        repeat (3) step();
        rst_n = 1'b1;
        repeat (100) step();
        check("arst_restart_hold", 32'(link.tx_rst), 1);
        wait_tx_rst(1'b0, 3000, n);
        check("arst_restart_lat", n + 100, 1045);
        wait_up(400, n);
        check("arst_up_lat", n, 256);

        // lock drop on the SETTLE->RUN terminal cycle
        mmcm_locked = 1'b0;
        repeat (4) step();
        mmcm_locked = 1'b1;
        wait_tx_rst(1'b0, 3000, n);
        repeat (253) step();
        mmcm_locked = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (link.link_up === 1'b1) seen = 1'b1;
        end
        check("term_no_link_up", 32'(seen), 0);
        check("term_tx_rst", 32'(link.tx_rst), 1);

`ifdef HDMITX_LOCK_TIMEOUT_EN
        // lock held low: periodic MMCM reset
        n = 0;
        while (link.mmcm_rst !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        w = 0;
        while (link.mmcm_rst === 1'b1 && w < 50) begin
            step();
            w++;
        end
        check("tmo_pulse_width", w, 16);
        n = 0;
        while (link.mmcm_rst !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        check("tmo_period", w + n, 116);
`else
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (link.mmcm_rst !== 1'b0) seen = 1'b1;
        end
        check("no_mmcm_rst", 32'(seen), 0);
        w = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
